// File: rtl/deser_181_if.sv
// deser_181_if: bundles the bit-side and word-side handshake of the
// serial-to-parallel deserializer.
//   inClear     - flush the partial byte (word side untouched)
//   inBit       - serial data bit, LSB first
//   inValid     - inBit is valid this cycle
//   outBitReady - deserializer can take a bit this cycle (combinational)
//   outData     - assembled 8-bit word (registered)
//   outValid    - outData holds an unconsumed word
//   inReady     - downstream takes outData this cycle
//   outBitIdx   - index of the next bit to be written (0..7)
// slave modport is the deserializer side, master the producer/consumer side.
interface deser_181_if;
  logic       inClear;
  logic       inBit;
  logic       inValid;
  logic       outBitReady;
  logic [7:0] outData;
  logic       outValid;
  logic       inReady;
  logic [2:0] outBitIdx;

  modport slave (
    input  inClear, inBit, inValid, inReady,
    output outBitReady, outData, outValid, outBitIdx
  );

  modport master (
    output inClear, inBit, inValid, inReady,
    input  outBitReady, outData, outValid, outBitIdx
  );
endinterface

// File: rtl/deser_181.sv
// deser_181: collects single bits LSB-first and presents them as 8-bit words
// with a valid/ready handshake. Bit k of a word is the k-th accepted bit.
// Ports:
//   inClk - clock, rising edge
//   inRst - synchronous active-high reset (clears everything, drops held word)
//   bus   - deser_181_if.slave carrying the bit and word handshakes
module deser_181 (
  input  logic         inClk,
  input  logic         inRst,
  deser_181_if.slave   bus
);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t     r_state;
  logic [2:0] r_idx;
  logic [6:0] r_shift;
  logic [7:0] r_data;

  logic w_bitReady;
  logic w_accept;
  logic w_complete;
  logic w_consume;

  // Only the 8th bit can be stalled: it needs the output slot to be free or
  // being drained in the same cycle, so inReady passes straight through.
  assign w_bitReady = (r_idx != 3'd7) || (r_state == EMPTY) || bus.inReady;
  assign w_accept   = bus.inValid && w_bitReady && !bus.inClear;
  assign w_complete = w_accept && (r_idx == 3'd7);
  assign w_consume  = (r_state == HOLD) && bus.inReady;

  assign bus.outBitReady = w_bitReady;
  assign bus.outData     = r_data;
  assign bus.outValid    = (r_state == HOLD);
  assign bus.outBitIdx   = r_idx;

  always_ff @(posedge inClk) begin
    if (inRst) begin
      r_state <= EMPTY;
      r_idx   <= 3'd0;
      r_shift <= 7'd0;
      r_data  <= 8'd0;
    end else begin
      // Bit side. The partial shift register is never cleared: every
      // position is rewritten before the word that uses it completes.
      if (bus.inClear) begin
        r_idx <= 3'd0;
      end else if (w_accept) begin
        if (r_idx == 3'd7) begin
          r_data <= {bus.inBit, r_shift};
          r_idx  <= 3'd0;
        end else begin
          for (int k = 0; k < 7; k++) begin
            if (r_idx == 3'(k)) r_shift[k] <= bus.inBit;
          end
          r_idx <= r_idx + 3'd1;
        end
      end

      // Word side. A completion in the same cycle as a consume keeps HOLD,
      // so back-to-back words leave no bubble.
      case (r_state)
        EMPTY: if (w_complete) r_state <= HOLD;
        HOLD:  if (w_consume && !w_complete) r_state <= EMPTY;
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule
